// File: rtl/std_cache_pkg.sv
// Shared cache-side types for the bypass path and the bypass arbiter state enum.
package std_cache_pkg;

    // Request from one requester onto the shared bypass path.
    typedef struct packed {
        logic        req;
        logic        we;
        logic [7:0]  be;
        logic [63:0] addr;
        logic [63:0] wdata;
    } bypass_req_t;

    // Response from the shared bypass path (and to each requester).
    typedef struct packed {
        logic        gnt;
        logic        valid;
        logic [63:0] rdata;
    } bypass_rsp_t;

    // Bypass arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } bypass_arb_state_t;

    // Saturation value of the optional stall counter.
    localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/std_bypass_rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping modulo NR_PORTS.
// Purely combinational; one-hot and binary index of the winner.
module std_bypass_rr_pick #(
    parameter int unsigned NR_PORTS = 4,
    localparam int unsigned IDX_W = $clog2(NR_PORTS)
) (
    input  logic [NR_PORTS-1:0] req,
    input  logic [IDX_W-1:0]    ptr,
    output logic [NR_PORTS-1:0] onehot,
    output logic [IDX_W-1:0]    idx
);

    logic [NR_PORTS-1:0] upper;
    logic [NR_PORTS-1:0] cand;

    // Requests at or above the pointer take priority over the wrapped-around ones.
    genvar gi;
    for (gi = 0; gi < NR_PORTS; gi++) begin : g_upper
        assign upper[gi] = req[gi] && (IDX_W'(gi) >= ptr);
    end

    // Lowest set bit of the candidate vector is the winner.
    always_comb begin
        cand   = (|upper) ? upper : req;
        onehot = cand & ~(cand - NR_PORTS'(1));
        idx    = '0;
        for (int i = NR_PORTS - 1; i >= 0; i--) begin
            if (cand[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/std_bypass_arbiter.sv
// Round-robin arbiter granting one of NR_PORTS bypass requesters access to a
// single shared bypass path, one transaction outstanding at a time.
// Optional feature: define STD_BYPASS_ARB_STALL_CNT_EN to add stall_cnt_o,
// a saturating count of REQ cycles spent waiting for a grant.
module std_bypass_arbiter
    import std_cache_pkg::*;
#(
    parameter int unsigned NR_PORTS = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  bypass_req_t req_i [NR_PORTS],
    output bypass_rsp_t rsp_o [NR_PORTS],
    output bypass_req_t req_o,
    input  bypass_rsp_t rsp_i
`ifdef STD_BYPASS_ARB_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);

    localparam int unsigned IDX_W = $clog2(NR_PORTS);

    bypass_arb_state_t   state_q;
    logic [IDX_W-1:0]    sel_q;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    ptr_next;
    logic [NR_PORTS-1:0] req_vec;
    logic [NR_PORTS-1:0] pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;
    bypass_req_t         sel_req;
    bypass_rsp_t         fwd_rsp;

    genvar gi;
    for (gi = 0; gi < NR_PORTS; gi++) begin : g_req_vec
        assign req_vec[gi] = req_i[gi].req;
    end

    std_bypass_rr_pick #(
        .NR_PORTS (NR_PORTS)
    ) u_pick (
        .req    (req_vec),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    assign pick_valid = |pick_onehot;
    assign sel_req    = req_i[sel_q];
    // Explicit wrap so non-power-of-2 port counts return to 0.
    assign ptr_next   = (sel_q == IDX_W'(NR_PORTS - 1)) ? '0 : sel_q + IDX_W'(1);

    // Arbitration FSM: pick in IDLE, forward in REQ, wait for data in WAIT_RSP.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            rr_ptr  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        sel_q   <= pick_idx;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (!sel_req.req) begin
                        // Requester withdrew before grant: drop it, pointer untouched.
                        state_q <= IDLE;
                    end else if (rsp_i.gnt) begin
                        if (rsp_i.valid) begin
                            rr_ptr  <= ptr_next;
                            state_q <= IDLE;
                        end else begin
                            state_q <= WAIT_RSP;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (rsp_i.valid) begin
                        rr_ptr  <= ptr_next;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Shared-path request: nothing in IDLE, selected port in REQ, fields only in WAIT_RSP.
    always_comb begin
        req_o = '0;
        case (state_q)
            REQ: req_o = sel_req;
            WAIT_RSP: begin
                req_o     = sel_req;
                req_o.req = 1'b0;
            end
            default: req_o = '0;
        endcase
    end

    // Response routed to the selected port; responses outside a transaction are dropped.
    always_comb begin
        fwd_rsp = '0;
        case (state_q)
            REQ: begin
                if (sel_req.req) begin
                    fwd_rsp.gnt   = rsp_i.gnt;
                    fwd_rsp.valid = rsp_i.gnt && rsp_i.valid;
                end
            end
            WAIT_RSP: fwd_rsp.valid = rsp_i.valid;
            default: fwd_rsp = '0;
        endcase
        fwd_rsp.rdata = fwd_rsp.valid ? rsp_i.rdata : '0;
    end

    for (gi = 0; gi < NR_PORTS; gi++) begin : g_rsp
        assign rsp_o[gi] = (sel_q == IDX_W'(gi)) ? fwd_rsp : '0;
    end

`ifdef STD_BYPASS_ARB_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Count cycles in REQ without a grant, saturating at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (state_q == REQ && !rsp_i.gnt && stall_cnt_q != STALL_CNT_MAX) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_std_bypass_arbiter.sv
// Self-checking bench for std_bypass_arbiter (4-port main instance, 3-port wrap instance).
module tb_std_bypass_arbiter;
    import std_cache_pkg::*;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    bypass_req_t req_i [N];
    bypass_rsp_t rsp_o [N];
    bypass_req_t req_o;
    bypass_rsp_t rsp_i;
    bypass_req_t req3 [3];
    bypass_rsp_t rsp3_o [3];
    bypass_req_t req3_o;
    bypass_rsp_t rsp3_i;
`ifdef STD_BYPASS_ARB_STALL_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] stall_cnt3;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    std_bypass_arbiter #(.NR_PORTS(N)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .req_i (req_i),
        .rsp_o (rsp_o),
        .req_o (req_o),
        .rsp_i (rsp_i)
`ifdef STD_BYPASS_ARB_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    std_bypass_arbiter #(.NR_PORTS(3)) dut3 (
        .clk_i (clk),
        .rst_i (rst),
        .req_i (req3),
        .rsp_o (rsp3_o),
        .req_o (req3_o),
        .rsp_i (rsp3_i)
`ifdef STD_BYPASS_ARB_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt3)
`endif
    );

    function automatic logic [63:0] port_addr(int p);
        return 64'h1000 + 64'(p) * 64'h40;
    endfunction

    task automatic clear_inputs();
        for (int p = 0; p < N; p++) req_i[p] = '0;
        for (int p = 0; p < 3; p++) req3[p] = '0;
        rsp_i  = '0;
        rsp3_i = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic raise_req(int p, logic [63:0] a);
        req_i[p].req  = 1'b1;
        req_i[p].we   = 1'b0;
        req_i[p].be   = 8'hFF;
        req_i[p].addr = a;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        for (int p = 0; p < N; p++) raise_req(p, port_addr(p));
        rsp_i.gnt = 1'b1; rsp_i.valid = 1'b1; rsp_i.rdata = 64'h55;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (req_o !== '0) begin
            fails++; $display("FAIL reset_req_o: got %h expected 0", req_o);
        end
        for (int p = 0; p < N; p++) begin
            checks++;
            if (rsp_o[p] !== '0) begin
                fails++; $display("FAIL reset_rsp_o[%0d]: got %h expected 0", p, rsp_o[p]);
            end
        end
        rst = 1'b0;
        clear_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_single_read();
        do_reset();
        raise_req(2, 64'h8000_0010);
        @(negedge clk);
        checks++;
        if (req_o !== '0) begin
            fails++; $display("FAIL idle_latency: req_o got %h expected 0", req_o);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (req_o.req !== 1'b1 || req_o.addr !== 64'h8000_0010 || req_o.we !== 1'b0) begin
            fails++; $display("FAIL single_req_o: got req=%b addr=%h we=%b expected 1/80000010/0",
                              req_o.req, req_o.addr, req_o.we);
        end
        rsp_i.gnt = 1'b1;
        #1;
        for (int p = 0; p < N; p++) begin
            checks++;
            if (rsp_o[p].gnt !== 1'(p == 2) || rsp_o[p].valid !== 1'b0) begin
                fails++; $display("FAIL single_gnt[%0d]: got gnt=%b valid=%b expected gnt=%b valid=0",
                                  p, rsp_o[p].gnt, rsp_o[p].valid, p == 2);
            end
        end
        @(posedge clk); #1;
        req_i[2].req = 1'b0;
        rsp_i = '0;
        @(negedge clk);
        checks++;
        if (req_o.req !== 1'b0 || req_o.addr !== 64'h8000_0010) begin
            fails++; $display("FAIL single_wait_req_o: got req=%b addr=%h expected 0/80000010",
                              req_o.req, req_o.addr);
        end
        @(posedge clk); #1;
        @(negedge clk);
        rsp_i.valid = 1'b1; rsp_i.rdata = 64'hDEAD_BEEF;
        #1;
        for (int p = 0; p < N; p++) begin
            checks++;
            if (rsp_o[p].valid !== 1'(p == 2) || rsp_o[p].rdata !== ((p == 2) ? 64'hDEAD_BEEF : 64'h0)) begin
                fails++; $display("FAIL single_valid[%0d]: got valid=%b rdata=%h", p, rsp_o[p].valid, rsp_o[p].rdata);
            end
        end
        @(posedge clk); #1;
        rsp_i = '0;
        // Pointer should now be 3: with everyone requesting, port 3 goes first.
        for (int p = 0; p < N; p++) raise_req(p, port_addr(p));
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (req_o.req !== 1'b1 || req_o.addr !== port_addr(3)) begin
            fails++; $display("FAIL single_rr_ptr: got addr=%h expected %h", req_o.addr, port_addr(3));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fairness();
        int got;
        int done;
        int budget;
        logic [63:0] rd;
        do_reset();
        for (int p = 0; p < N; p++) raise_req(p, port_addr(p));
        done = 0; budget = 0;
        while (done < 5 && budget < 40) begin
            budget++;
            @(negedge clk);
            if (req_o.req === 1'b1) begin
                rd = {$urandom, $urandom};
                rsp_i.gnt = 1'b1; rsp_i.valid = 1'b1; rsp_i.rdata = rd;
                #1;
                got = -1;
                for (int p = 0; p < N; p++) if (rsp_o[p].valid === 1'b1) got = p;
                checks++;
                if (got != done % N || rsp_o[done % N].rdata !== rd || rsp_o[done % N].gnt !== 1'b1) begin
                    fails++; $display("FAIL fair_order: completion %0d got port %0d expected port %0d", done, got, done % N);
                end
                done++;
            end
            @(posedge clk); #1;
            rsp_i = '0;
        end
        checks++;
        if (done != 5) begin
            fails++; $display("FAIL fair_timeout: got %0d completions expected 5", done);
        end
    endtask

    task automatic test_abort();
        do_reset();
        raise_req(1, port_addr(1));
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (req_o.req !== 1'b1 || req_o.addr !== port_addr(1)) begin
            fails++; $display("FAIL abort_req_o: got req=%b addr=%h expected 1/%h", req_o.req, req_o.addr, port_addr(1));
        end
        req_i[1].req = 1'b0;
        #1;
        for (int p = 0; p < N; p++) begin
            checks++;
            if (rsp_o[p] !== '0) begin
                fails++; $display("FAIL abort_rsp[%0d]: got %h expected 0", p, rsp_o[p]);
            end
        end
        @(posedge clk); #1;
        // Back in IDLE: stray gnt/valid must not reach anyone.
        rsp_i.gnt = 1'b1; rsp_i.valid = 1'b1; rsp_i.rdata = 64'h1234;
        #1;
        checks++;
        if (req_o !== '0) begin
            fails++; $display("FAIL abort_idle_req_o: got %h expected 0", req_o);
        end
        for (int p = 0; p < N; p++) begin
            checks++;
            if (rsp_o[p] !== '0) begin
                fails++; $display("FAIL abort_idle_rsp[%0d]: got %h expected 0", p, rsp_o[p]);
            end
        end
        @(posedge clk); #1;
        rsp_i = '0;
        for (int p = 0; p < N; p++) raise_req(p, port_addr(p));
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (req_o.addr !== port_addr(0)) begin
            fails++; $display("FAIL abort_rr_ptr: got addr=%h expected %h", req_o.addr, port_addr(0));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        raise_req(0, port_addr(0));
        @(posedge clk); #1;
        @(negedge clk);
        rsp_i.gnt = 1'b1;
        @(posedge clk); #1;
        rsp_i = '0;
        req_i[0].req = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            rsp_i.valid = 1'b1; rsp_i.rdata = 64'hCAFE_0000 + 64'(c);
            #1;
            checks++;
            if (req_o !== '0) begin
                fails++; $display("FAIL rstmid_req_o: got %h expected 0", req_o);
            end
            for (int p = 0; p < N; p++) begin
                checks++;
                if (rsp_o[p] !== '0) begin
                    fails++; $display("FAIL rstmid_rsp[%0d]: got %h expected 0", p, rsp_o[p]);
                end
            end
            @(posedge clk); #1;
            rsp_i = '0;
        end
    endtask

    task automatic test_random();
        int          ptr_m;
        int          exp_q[$];
        logic [63:0] addr_m [N];
        int          budget;
        logic        waiting;
        int          delay;
        int          head;
        int          drop;
        int          mask;
        logic        imm;
        logic [63:0] rd;
        do_reset();
        ptr_m = 0;
        drop  = -1;
        for (int r = 0; r < 25; r++) begin
            mask = $urandom_range(1, (1 << N) - 1);
            exp_q.delete();
            for (int k = 0; k < N; k++) begin
                if (mask[(ptr_m + k) % N]) exp_q.push_back((ptr_m + k) % N);
            end
            for (int p = 0; p < N; p++) begin
                if (mask[p]) begin
                    addr_m[p] = {$urandom, $urandom};
                    raise_req(p, addr_m[p]);
                    req_i[p].we = 1'($urandom % 2);
                end
            end
            waiting = 1'b0; delay = 0; budget = 0;
            while (exp_q.size() > 0 && budget < 200) begin
                budget++;
                @(negedge clk);
                head = exp_q[0];
                if (waiting) begin
                    checks++;
                    if (req_o.req !== 1'b0) begin
                        fails++; $display("FAIL rand_wait_req: got req=%b expected 0", req_o.req);
                    end
                    if (delay == 0) begin
                        rd = {$urandom, $urandom};
                        rsp_i.valid = 1'b1; rsp_i.rdata = rd;
                        #1;
                        for (int p = 0; p < N; p++) begin
                            checks++;
                            if (rsp_o[p].valid !== 1'(p == head) || rsp_o[p].rdata !== ((p == head) ? rd : 64'h0)) begin
                                fails++; $display("FAIL rand_valid[%0d]: got valid=%b rdata=%h expected winner %0d",
                                                  p, rsp_o[p].valid, rsp_o[p].rdata, head);
                            end
                        end
                        void'(exp_q.pop_front());
                        ptr_m = (head + 1) % N;
                        waiting = 1'b0;
                    end else begin
                        delay--;
                    end
                end else if (req_o.req === 1'b1) begin
                    checks++;
                    if (req_o.addr !== addr_m[head]) begin
                        fails++; $display("FAIL rand_winner: got addr=%h expected port %0d addr=%h", req_o.addr, head, addr_m[head]);
                    end
                    if ($urandom_range(0, 2) != 0) begin
                        imm = 1'($urandom % 2);
                        rd  = {$urandom, $urandom};
                        rsp_i.gnt = 1'b1; rsp_i.valid = imm; rsp_i.rdata = rd;
                        #1;
                        for (int p = 0; p < N; p++) begin
                            checks++;
                            if (rsp_o[p].gnt !== 1'(p == head) || rsp_o[p].valid !== 1'(imm && p == head) ||
                                rsp_o[p].rdata !== ((imm && p == head) ? rd : 64'h0)) begin
                                fails++; $display("FAIL rand_gnt[%0d]: got gnt=%b valid=%b expected winner %0d imm=%b",
                                                  p, rsp_o[p].gnt, rsp_o[p].valid, head, imm);
                            end
                        end
                        drop = head;
                        if (imm) begin
                            void'(exp_q.pop_front());
                            ptr_m = (head + 1) % N;
                        end else begin
                            waiting = 1'b1;
                            delay = $urandom_range(0, 3);
                        end
                    end else begin
                        #1;
                        for (int p = 0; p < N; p++) begin
                            checks++;
                            if (rsp_o[p].gnt !== 1'b0) begin
                                fails++; $display("FAIL rand_nognt[%0d]: got gnt=%b expected 0", p, rsp_o[p].gnt);
                            end
                        end
                    end
                end
                @(posedge clk); #1;
                rsp_i = '0;
                if (drop >= 0) req_i[drop].req = 1'b0;
                drop = -1;
            end
            checks++;
            if (exp_q.size() != 0) begin
                fails++; $display("FAIL rand_timeout: round %0d left %0d pending", r, exp_q.size());
            end
        end
    endtask

    task automatic test_n3_wrap();
        int budget;
        logic seen;
        do_reset();
        for (int t = 0; t < 2; t++) begin
            req3[2].req = 1'b1; req3[2].addr = 64'hA000 + 64'(t);
            seen = 1'b0; budget = 0;
            while (!seen && budget < 10) begin
                budget++;
                @(negedge clk);
                if (req3_o.req === 1'b1) begin
                    seen = 1'b1;
                    rsp3_i.gnt = 1'b1; rsp3_i.valid = 1'b1; rsp3_i.rdata = 64'hB0 + 64'(t);
                    #1;
                    checks++;
                    if (req3_o.addr !== 64'hA000 + 64'(t) || rsp3_o[2].valid !== 1'b1 ||
                        rsp3_o[2].rdata !== 64'hB0 + 64'(t) || rsp3_o[0].valid !== 1'b0 || rsp3_o[1].valid !== 1'b0) begin
                        fails++; $display("FAIL n3_port2_%0d: got addr=%h valid2=%b rdata2=%h", t,
                                          req3_o.addr, rsp3_o[2].valid, rsp3_o[2].rdata);
                    end
                end
                @(posedge clk); #1;
                rsp3_i = '0;
                if (seen) req3[2].req = 1'b0;
            end
            checks++;
            if (!seen) begin
                fails++; $display("FAIL n3_timeout_%0d: got no request expected one", t);
            end
        end
        // Pointer wrapped 2 -> 0: port 0 wins among all three.
        for (int p = 0; p < 3; p++) begin
            req3[p].req = 1'b1; req3[p].addr = 64'hC000 + 64'(p);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (req3_o.req !== 1'b1 || req3_o.addr !== 64'hC000) begin
            fails++; $display("FAIL n3_wrap: got req=%b addr=%h expected 1/c000", req3_o.req, req3_o.addr);
        end
        @(posedge clk); #1;
        clear_inputs();
    endtask

`ifdef STD_BYPASS_ARB_STALL_CNT_EN
    task automatic test_stall_cnt();
        do_reset();
        checks++;
        if (stall_cnt !== 32'd0) begin
            fails++; $display("FAIL stall_reset: got %0d expected 0", stall_cnt);
        end
        raise_req(0, port_addr(0));
        @(posedge clk); #1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        rsp_i.gnt = 1'b1; rsp_i.valid = 1'b1;
        @(posedge clk); #1;
        rsp_i = '0; req_i[0].req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (stall_cnt !== 32'd5) begin
            fails++; $display("FAIL stall_count: got %0d expected 5", stall_cnt);
        end
        do_reset();
        checks++;
        if (stall_cnt !== 32'd0) begin
            fails++; $display("FAIL stall_after_reset: got %0d expected 0", stall_cnt);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_fairness();
        test_abort();
        test_reset_mid();
        test_random();
        test_n3_wrap();
`ifdef STD_BYPASS_ARB_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/std_bypass_arbiter.md
STD_BYPASS_ARBITER -- requirements
Module: std_bypass_arbiter

Interface
REQ-001 Parameter NR_PORTS, default 4: number of bypass requesters; legal range 2..16.
REQ-002 clk_i  input  1  clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 req_i  input  NR_PORTS x bypass_req_t  per-port bypass requests; held stable until granted.
REQ-005 rsp_o  output  NR_PORTS x bypass_rsp_t  per-port gnt/valid/rdata.
REQ-006 req_o  output  bypass_req_t  request to the shared bypass path.
REQ-007 rsp_i  input  bypass_rsp_t  shared bypass path response.

Function
REQ-008 The FSM SHALL have three states: IDLE, REQ and WAIT_RSP.
REQ-009 IDLE: if any req_i[i].req is set, pick the first requesting port at or after rr_ptr (wrapping modulo NR_PORTS), latch its index in sel_q, and go to REQ; otherwise stay in IDLE.
REQ-010 In IDLE, req_o SHALL be all-zero, giving one cycle of arbitration latency.
REQ-011 REQ: req_o SHALL equal req_i[sel_q] combinationally.
REQ-012 REQ: rsp_o[sel_q].gnt SHALL equal rsp_i.gnt; every other port's gnt SHALL be 0.
REQ-013 REQ, rsp_i.gnt=1 and rsp_i.valid=0: go to WAIT_RSP.
REQ-014 REQ, rsp_i.gnt=1 and rsp_i.valid=1 in the same cycle: complete as in REQ-017 and go to IDLE.
REQ-015 REQ, req_i[sel_q].req=0 before grant (aborted request): go to IDLE; rr_ptr unchanged; nothing forwarded to any port.
REQ-016 WAIT_RSP: req_o.req SHALL be 0; all other req_o fields hold req_i[sel_q].
REQ-017 Completion (rsp_i.valid=1 in WAIT_RSP, or as in REQ-014): rsp_o[sel_q].valid=1 and rsp_o[sel_q].rdata=rsp_i.rdata that cycle; rr_ptr <= (sel_q+1) mod NR_PORTS; go to IDLE.
REQ-018 Only one transaction SHALL be outstanding at a time; rsp_i.gnt and rsp_i.valid arriving in IDLE SHALL be ignored.
REQ-019 rsp_o[i].rdata SHALL be 0 whenever rsp_o[i].valid=0.
REQ-020 Fairness: with all ports requesting continuously, grants SHALL rotate 0,1,...,NR_PORTS-1,0,...
REQ-021 rr_ptr and sel_q SHALL be $clog2(NR_PORTS) bits wide; the increment SHALL wrap to 0 after NR_PORTS-1, including for non-power-of-2 NR_PORTS.

Reset
REQ-022 Reset SHALL force state to IDLE, rr_ptr to 0 and sel_q to 0, and drive all rsp_o and req_o to zero.
REQ-023 Reset asserted mid-transaction SHALL abandon it silently; responses arriving after release SHALL be ignored per REQ-018.

Configuration
REQ-024 Macro STD_BYPASS_ARB_STALL_CNT_EN defined: add output stall_cnt_o (32 bits).
REQ-025 stall_cnt_o SHALL count cycles spent in REQ with rsp_i.gnt=0, saturate at 32'hFFFF_FFFF, and reset to 0.
REQ-026 Macro STD_BYPASS_ARB_STALL_CNT_EN undefined: no stall_cnt_o port and no counter logic.

Structure
REQ-027 bypass_req_t and bypass_rsp_t SHALL come from std_cache_pkg.
REQ-028 The FSM state enum bypass_arb_state_t SHALL be added to std_cache_pkg.
REQ-029 The round-robin pick (request vector plus pointer in, one-hot plus index out, purely combinational) SHALL be the sub-module std_bypass_rr_pick.

Verification
REQ-030 NR_PORTS=4; port 2 requests addr=64'h8000_0010 with we=0; gnt in cycle 2; valid with rdata=64'hDEAD_BEEF in cycle 4 -> req_o.addr=64'h8000_0010 during REQ; rsp_o[2].valid=1 with rdata=64'hDEAD_BEEF in cycle 4; rr_ptr=3.
REQ-031 All 4 ports request continuously with immediate gnt+valid -> completions in order 0,1,2,3,0; each port receives exactly one gnt per round.
REQ-032 Port 1 drops req in REQ before gnt -> FSM returns to IDLE; no gnt or valid on any port; rr_ptr stays 0.
REQ-033 rst_i asserted during WAIT_RSP, then rsp_i.valid=1 after release -> all rsp_o remain 0; FSM in IDLE.
REQ-034 NR_PORTS=3 with only port 2 requesting twice -> rr_ptr wraps 2->0; port 2 wins the second arbitration.
REQ-035 With STD_BYPASS_ARB_STALL_CNT_EN defined, gnt withheld for 5 REQ cycles -> stall_cnt_o=5; after reset stall_cnt_o=0.
